stage_chain_ctrl: RTL and testbench
===================================

Name: stage_chain_ctrl

Overview:
Flow-control sequencer for a linear chain of NUM_STAGES registered processing stages, such as a stage1→stage2→stage3 cascade of sub instances. It owns the per-stage valid bits and drives per-stage load enables. It exposes a valid/ready handshake at both ends of the chain, collapses bubbles, and provides drain and flush control plus an output beat counter. The datapath registers are external; this block only sequences them.

Parameters:
NUM_STAGES, 2, number of registered stages in the chain (≥1)
CNT_W, 16, width of output beat counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  upstream beat valid
in_ready  output  1  upstream beat accepted when in_valid && in_ready
out_valid  output  1  last stage holds a valid beat
out_ready  input  1  downstream accepts beat
stage_en  output  NUM_STAGES  load enable for stage i data register (bit 0 = first stage)
stage_vld  output  NUM_STAGES  per-stage valid bits
drain_req  input  1  request: stop accepting, empty the chain
drain_done  output  1  one-cycle pulse when drain completes
flush  input  1  synchronous discard of all in-flight beats
busy  output  1  any stage valid or drain in progress
beat_cnt  output  CNT_W  count of completed output transfers

Behaviour:
- Reset (async, rst=1): stage_vld=0, state=IDLE, drain_done=0, beat_cnt=0. Consequently out_valid=0, busy=0, in_ready=1, and stage_en is all ones (empty stages).
- Enables are combinational. stage_en[N-1] = !vld[N-1] || out_ready. For i<N-1: stage_en[i] = !vld[i] || stage_en[i+1]. This provides bubble collapse: an empty stage always loads.
- in_ready = stage_en[0] && state!=DRAIN && !flush. A combinational path from out_ready to in_ready is intended.
- Valid update on rising clk when stage_en[i]=1:
  - vld[0] ← in_valid && in_ready.
  - vld[i] ← vld[i-1] for i>0.
  - Otherwise vld[i] holds.
- out_valid = vld[N-1]. Output transfer = out_valid && out_ready.
- Latency: with no stall, a beat accepted in cycle t gives out_valid in cycle t+NUM_STAGES.
- Throughput: 1 beat/cycle.
- Stall: out_valid held with out_ready=0 freezes only the contiguous full stages behind it. Earlier empty stages keep filling. in_ready drops only when all stages are valid and the output is stalled.
- beat_cnt increments by 1 per output transfer and wraps 2^CNT_W-1 → 0. It is cleared only by rst; flush does not clear it.
- flush has priority over every other action:
  - Next cycle, all vld=0.
  - No input is accepted in the flush cycle.
  - An output transfer coinciding with flush still counts in beat_cnt.
- State machine (registered): IDLE, RUN, DRAIN.
  - IDLE→RUN on an accepted beat.
  - RUN→IDLE when vld becomes all-zero and drain_req=0.
  - IDLE/RUN→DRAIN when drain_req=1 is sampled. A beat accepted in that same cycle is still accepted and drained.
  - In DRAIN, in_ready=0 and the chain empties via normal output transfers.
  - DRAIN→IDLE in the first cycle where registered vld==0. drain_done=1 for exactly that cycle, registered.
  - drain_req while already in DRAIN is ignored.
  - drain_req sampled in IDLE with an empty chain gives DRAIN for one cycle, then a drain_done pulse.
- Flush during DRAIN empties the chain, so drain_done pulses the following cycle.
- busy = (|vld) || state==DRAIN.
- A mid-operation reset abandons all beats immediately, with the outputs at their reset values.

Test Plan:
- Streaming, NUM_STAGES=2: in_valid=1 on 4 consecutive cycles, out_ready=1 → out_valid cycles t+2..t+5, beat_cnt=4, in_ready stays 1.
- Back-pressure: fill the chain, out_ready=0 for 3 cycles → stage_vld=2'b11, in_ready=0, stage_en=0. Then release → beats emerge in order, no loss or duplication.
- Bubble collapse: accept a beat, 1 idle cycle, accept a second while out_ready=0 → stage_vld reaches 2'b11 and stage_en[0] was 1 while vld[0]=0.
- Drain: 2 beats in flight, drain_req pulse with in_valid=1 in the same cycle → that beat is accepted, in_ready=0 thereafter, 3 output transfers, drain_done pulses once when empty, state returns to IDLE.
- Flush with stall: chain full, out_ready=0, flush=1 for one cycle → next cycle stage_vld=0, out_valid=0, beat_cnt unchanged, in_ready=1.
- Counter wrap with CNT_W=4: 17 transfers → beat_cnt=1. Assert rst mid-stream → stage_vld=0 and beat_cnt=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/stage_chain_ctrl.sv
// Valid/enable sequencer for a linear chain of externally registered stages.
// Collapses bubbles, supports drain and flush, and counts output transfers.
//
// state | meaning
// IDLE  | chain empty, accepting beats
// RUN   | at least one beat in flight, accepting beats
// DRAIN | input closed, chain empties through normal output transfers
module stage_chain_ctrl #(
   parameter int NUM_STAGES = 2,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic [NUM_STAGES-1:0] stage_vld,
   input  logic                  drain_req,
   output logic                  drain_done,
   input  logic                  flush,
   output logic                  busy,
   output logic [CNT_W-1:0]      beat_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state;
   logic [NUM_STAGES-1:0] vld;
   logic [NUM_STAGES-1:0] vld_nxt;
   logic [NUM_STAGES-1:0] en;
   logic                  accept;
   logic                  xfer;

   // A stage loads when it is empty or its successor is moving; this
   // ripples back from the output so only the contiguous full tail stalls.
   always_comb begin
      en = '0;
      en[NUM_STAGES-1] = !vld[NUM_STAGES-1] || out_ready;
      for (int i = NUM_STAGES - 2; i >= 0; i--) begin
         en[i] = !vld[i] || en[i+1];
      end
   end

   assign in_ready = en[0] && (state != DRAIN) && !flush;
   assign accept   = in_valid && in_ready;
   assign xfer     = vld[NUM_STAGES-1] && out_ready;

   always_comb begin
      vld_nxt = vld;
      if (flush) begin
         vld_nxt = '0;
      end else begin
         if (en[0]) begin
            vld_nxt[0] = accept;
         end
         for (int i = 1; i < NUM_STAGES; i++) begin
            if (en[i]) begin
               vld_nxt[i] = vld[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld        <= '0;
         state      <= IDLE;
         drain_done <= 1'b0;
         beat_cnt   <= '0;
      end else begin
         vld        <= vld_nxt;
         drain_done <= 1'b0;
         if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
         case (state)
            IDLE: begin
               if (drain_req) begin
                  state <= DRAIN;
               end else if (accept) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (drain_req) begin
                  state <= DRAIN;
               end else if (vld_nxt == '0) begin
                  state <= IDLE;
               end
            end
            DRAIN: begin
               // Done is raised together with the first empty cycle.
               if (vld_nxt == '0) begin
                  state      <= IDLE;
                  drain_done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign stage_en  = en;
   assign stage_vld = vld;
   assign out_valid = vld[NUM_STAGES-1];
   assign busy      = (|vld) || (state == DRAIN);

endmodule

// File: tb/tb_stage_chain_ctrl.sv
// Randomized and directed bench for stage_chain_ctrl against an occupancy-array model.
// Uses a 4-bit beat counter so wrap-around is reachable quickly.
module tb_stage_chain_ctrl;

   localparam int NS = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [NS-1:0] stage_en;
   logic [NS-1:0] stage_vld;
   logic          drain_req;
   logic          drain_done;
   logic          flush;
   logic          busy;
   logic [CW-1:0] beat_cnt;

   stage_chain_ctrl #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .stage_en   (stage_en),
      .stage_vld  (stage_vld),
      .drain_req  (drain_req),
      .drain_done (drain_done),
      .flush      (flush),
      .busy       (busy),
      .beat_cnt   (beat_cnt)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;
   int n_done     = 0;

   // model: occupancy per stage, drain-in-progress flag, pending done pulse, count
   bit m_occ [NS];
   bit m_drain;
   bit m_done;
   int m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) m_occ[i] = 1'b0;
      m_drain = 1'b0;
      m_done  = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic cycle(input bit iv, input bit ordy, input bit dreq, input bit fl);
      int            tail;
      bit            run;
      bit            en [NS];
      bit            nxt [NS];
      bit            ir;
      bit            any;
      logic [NS-1:0] e_en;
      logic [NS-1:0] e_vld;
      in_valid  = iv;
      out_ready = ordy;
      drain_req = dreq;
      flush     = fl;
      @(negedge clk);
      // stalled stages are exactly the run of full slots ending at the output
      tail = 0;
      run  = !ordy;
      for (int i = NS - 1; i >= 0; i--) begin
         if (run && m_occ[i]) tail++;
         else run = 1'b0;
      end
      any = 1'b0;
      for (int i = 0; i < NS; i++) begin
         en[i]    = (i < NS - tail);
         e_en[i]  = en[i];
         e_vld[i] = m_occ[i];
         any      = any | m_occ[i];
      end
      ir = en[0] && !m_drain && !fl;
      chk("in_ready",   in_ready,   ir);
      chk("out_valid",  out_valid,  m_occ[NS-1]);
      chk("stage_en",   stage_en,   e_en);
      chk("stage_vld",  stage_vld,  e_vld);
      chk("drain_done", drain_done, m_done);
      chk("busy",       busy,       any || m_drain);
      chk("beat_cnt",   beat_cnt,   m_cnt);
      vectors++;
      if (drain_done === 1'b1) n_done++;
      if (m_occ[NS-1] && ordy) m_cnt = (m_cnt + 1) % (1 << CW);
      for (int i = 0; i < NS; i++) nxt[i] = m_occ[i];
      if (fl) begin
         for (int i = 0; i < NS; i++) nxt[i] = 1'b0;
      end else begin
         for (int i = 1; i < NS; i++) if (en[i]) nxt[i] = m_occ[i-1];
         if (en[0]) nxt[0] = iv && ir;
      end
      any = 1'b0;
      for (int i = 0; i < NS; i++) begin
         m_occ[i] = nxt[i];
         any      = any | nxt[i];
      end
      m_done = 1'b0;
      if (m_drain) begin
         if (!any) begin
            m_drain = 1'b0;
            m_done  = 1'b1;
         end
      end else if (dreq) begin
         m_drain = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   // asserts rst wherever we are in the cycle and checks outputs before any edge
   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      drain_req = 1'b0;
      flush     = 1'b0;
      rst       = 1'b1;
      #1;
      chk("rst_stage_vld",  stage_vld,  0);
      chk("rst_beat_cnt",   beat_cnt,   0);
      chk("rst_out_valid",  out_valid,  0);
      chk("rst_busy",       busy,       0);
      chk("rst_drain_done", drain_done, 0);
      chk("rst_in_ready",   in_ready,   1);
      chk("rst_stage_en",   stage_en,   2'b11);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      model_reset();
      #2;
      do_reset();

      // streaming
      repeat (4) cycle(1, 1, 0, 0);
      repeat (4) cycle(0, 1, 0, 0);
      chk("stream_cnt", beat_cnt, 4);

      // back-pressure
      repeat (4) cycle(1, 0, 0, 0);
      chk("bp_vld", stage_vld, 2'b11);
      chk("bp_en", stage_en, 2'b00);
      chk("bp_in_ready", in_ready, 0);
      repeat (4) cycle(0, 1, 0, 0);
      chk("bp_cnt", beat_cnt, 6);

      // bubble collapse
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      chk("bub_en0", stage_en[0], 1);
      cycle(1, 0, 0, 0);
      chk("bub_vld", stage_vld, 2'b11);
      repeat (3) cycle(0, 1, 0, 0);
      chk("bub_cnt", beat_cnt, 8);

      // drain with a beat accepted alongside the request
      n_done = 0;
      repeat (2) cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 0);
      repeat (5) cycle(0, 1, 0, 0);
      chk("drain_cnt", beat_cnt, 11);
      chk("drain_pulses", n_done, 1);

      // drain from an empty chain
      n_done = 0;
      cycle(0, 0, 1, 0);
      repeat (3) cycle(0, 0, 0, 0);
      chk("edrain_pulses", n_done, 1);

      // flush with a stalled, full chain
      repeat (3) cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 1);
      in_valid = 1'b0;
      flush    = 1'b0;
      #1;
      chk("flush_vld", stage_vld, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_cnt", beat_cnt, 11);
      chk("flush_in_ready", in_ready, 1);

      // flush while draining
      n_done = 0;
      repeat (2) cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 1);
      repeat (3) cycle(0, 0, 0, 0);
      chk("fdrain_pulses", n_done, 1);

      // counter wrap
      do_reset();
      repeat (17) cycle(1, 1, 0, 0);
      repeat (3) cycle(0, 1, 0, 0);
      chk("wrap_cnt", beat_cnt, 1);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
      end

      // reset mid-stream, between clock edges
      repeat (3) cycle(1, 1, 0, 0);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #2;
      do_reset();
      repeat (3) cycle(1, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
